bp_update_ctrl: RTL and testbench

Sequences all writes into the dual-issue branch predictor's PHT/BTB tables.
- After reset, sweeps every table line with clear writes, so the predictor needs no single-cycle bulk reset.
- At run time, accepts up to two resolved-branch reports per cycle from the two EX pipes and buffers them in a small FIFO.
- Drains one update per cycle to the predictor's single write port.
- Flags per-slot mispredicts combinationally for the redirect logic.

---
 rtl/bp_pkg.sv | 48 ++++
 rtl/bp_upd_fifo.sv | 66 ++++++
 rtl/bp_update_ctrl.sv | 149 ++++++++++++++
 tb/tb_bp_update_ctrl.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/bp_pkg.sv
// Shared types and constants for the branch-predictor update controller.
// Table geometry is fixed here so entry and port widths agree everywhere.
// The update entry is the unit carried from the EX pipes to the write port.
package bp_pkg;

  localparam int BP_LINES = 256;
  localparam int IW       = $clog2(BP_LINES);
  localparam int TAG_W    = 32 - IW - 2;

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } bp_state_e;

  typedef struct packed {
    logic [IW-1:0]    index;
    logic [TAG_W-1:0] tag;
    logic             taken;
    logic             btb_we;
    logic [31:0]      target;
  } upd_entry_t;

  // Build a queued update from a resolved branch. The argument is the word address pc[31:2].
  function automatic upd_entry_t make_entry(input logic [29:0] pc_w,
                                            input logic        act_taken,
                                            input logic [31:0] act_target);
    upd_entry_t e;
    e.index  = pc_w[IW-1:0];
    e.tag    = pc_w[29:IW];
    e.taken  = act_taken;
    e.btb_we = act_taken;
    e.target = act_target;
    return e;
  endfunction

  // A non-jump predicted taken is always wrong; a jump is wrong on direction or on a taken target.
  function automatic logic calc_mispred(input logic        valid,
                                        input logic        is_jmp,
                                        input logic        act_taken,
                                        input logic        pred_taken,
                                        input logic [31:0] act_target,
                                        input logic [31:0] pred_target);
    logic jmp_wrong;
    jmp_wrong = (act_taken != pred_taken) | (act_taken & (act_target != pred_target));
    return valid & (is_jmp ? jmp_wrong : pred_taken);
  endfunction

endpackage

// File: rtl/bp_upd_fifo.sv
// Purpose: 2-write/1-read circular queue of predictor updates, reporting occupancy.
// Latency: an entry written at cycle N is visible on head at N+1 at the earliest.
// Backpressure: none toward writers; writes beyond free space (after this cycle's read) are dropped, write b first.
module bp_upd_fifo
  import bp_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_a,
  input  upd_entry_t                 dat_a,
  input  logic                       push_b,
  input  upd_entry_t                 dat_b,
  input  logic                       pop,
  output upd_entry_t                 head,
  output logic [$clog2(DEPTH):0]     count,
  output logic [1:0]                 drop_n
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  upd_entry_t        mem [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic              pop_ok;
  logic [CW:0]       free_now;
  logic              acc_a;
  logic              acc_b;
  logic [1:0]        n_acc;
  logic [PW-1:0]     wr_ptr_b;

  // Free space counts the slot released by this cycle's read; the older write claims space first.
  always_comb begin
    pop_ok   = pop & (count != '0);
    free_now = (CW+1)'(DEPTH) - {1'b0, count} + (CW+1)'(pop_ok);
    acc_a    = push_a & (free_now != '0);
    acc_b    = push_b & (free_now > (CW+1)'(acc_a));
    n_acc    = {1'b0, acc_a} + {1'b0, acc_b};
    drop_n   = {1'b0, push_a & ~acc_a} + {1'b0, push_b & ~acc_b};
    wr_ptr_b = acc_a ? wr_ptr + PW'(1) : wr_ptr;
  end

  // Storage array: no reset needed, occupancy decides what is valid.
  always_ff @(posedge clk) begin
    if (acc_a) mem[wr_ptr]   <= dat_a;
    if (acc_b) mem[wr_ptr_b] <= dat_b;
  end

  // Pointer and occupancy update; pointers wrap naturally since DEPTH is a power of 2.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + PW'(n_acc);
      rd_ptr <= rd_ptr + PW'(pop_ok);
      count  <= count + CW'(n_acc) - CW'(pop_ok);
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/bp_update_ctrl.sv
// Purpose: sequences predictor table writes: post-reset clear sweep, then queued resolved-branch updates.
// Latency: a branch pushed at cycle N reaches upd_* at N+1 at the earliest; mispred_* are combinational.
// Backpressure: stall_req asks EX to hold when fewer than 2 slots are free or the sweep runs; excess pushes are dropped and counted.
module bp_update_ctrl
  import bp_pkg::*;
#(
  parameter int LINES      = BP_LINES,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ex_stall,
  input  logic             ex_valid_1,
  input  logic             ex_valid_2,
  input  logic [31:0]      ex_pc_1,
  input  logic [31:0]      ex_pc_2,
  input  logic             ex_is_jmp_1,
  input  logic             ex_is_jmp_2,
  input  logic             ex_act_taken_1,
  input  logic             ex_act_taken_2,
  input  logic [31:0]      ex_act_target_1,
  input  logic [31:0]      ex_act_target_2,
  input  logic             ex_pred_taken_1,
  input  logic             ex_pred_taken_2,
  input  logic [31:0]      ex_pred_target_1,
  input  logic [31:0]      ex_pred_target_2,
  output logic             mispred_1,
  output logic             mispred_2,
  output logic             upd_valid,
  output logic             upd_clear,
  output logic [IW-1:0]    upd_index,
  output logic [TAG_W-1:0] upd_tag,
  output logic             upd_taken,
  output logic             upd_btb_we,
  output logic [31:0]      upd_target,
  output logic             init_busy,
  output logic             stall_req,
  output logic [7:0]       drop_cnt
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [IW-1:0] LAST_LINE = IW'(LINES - 1);

  bp_state_e     state;
  logic [IW-1:0] sweep_cnt;
  logic          in_run;
  logic          push_1;
  logic          push_2;
  logic          pop;
  upd_entry_t    ent_1;
  upd_entry_t    ent_2;
  upd_entry_t    head;
  logic [CW-1:0] fifo_count;
  logic [1:0]    drop_n;
  logic [CW:0]   free_slots;
  logic [8:0]    drop_sum;
  logic          unused_pc_lsbs;

  // Word-aligned PCs: the byte-offset bits never select a line.
  assign unused_pc_lsbs = ^{ex_pc_1[1:0], ex_pc_2[1:0]};

  // Mispredict flags ignore stall and FSM state so redirect logic always sees them.
  always_comb begin
    mispred_1 = calc_mispred(ex_valid_1, ex_is_jmp_1, ex_act_taken_1, ex_pred_taken_1,
                             ex_act_target_1, ex_pred_target_1);
    mispred_2 = calc_mispred(ex_valid_2, ex_is_jmp_2, ex_act_taken_2, ex_pred_taken_2,
                             ex_act_target_2, ex_pred_target_2);
  end

  // Push qualification and queue entry construction; slot 1 is older and goes in first.
  always_comb begin
    in_run = (state == ST_RUN) & ~rst;
    push_1 = ex_valid_1 & ex_is_jmp_1 & ~ex_stall & in_run;
    push_2 = ex_valid_2 & ex_is_jmp_2 & ~ex_stall & in_run;
    ent_1  = make_entry(ex_pc_1[31:2], ex_act_taken_1, ex_act_target_1);
    ent_2  = make_entry(ex_pc_2[31:2], ex_act_taken_2, ex_act_target_2);
    pop    = in_run & (fifo_count != '0);
  end

  bp_upd_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .push_a (push_1),
    .dat_a  (ent_1),
    .push_b (push_2),
    .dat_b  (ent_2),
    .pop    (pop),
    .head   (head),
    .count  (fifo_count),
    .drop_n (drop_n)
  );

  // INIT walks every line exactly once, then hands the write port to the queue.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_INIT;
      sweep_cnt <= '0;
    end else if (state == ST_INIT) begin
      sweep_cnt <= sweep_cnt + IW'(1);
      if (sweep_cnt == LAST_LINE) state <= ST_RUN;
    end
  end

  // Saturating add of this cycle's dropped pushes.
  always_comb begin
    drop_sum = {1'b0, drop_cnt} + 9'(drop_n);
  end

  // Drop counter register, saturating at 255.
  always_ff @(posedge clk) begin
    if (rst) drop_cnt <= '0;
    else     drop_cnt <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
  end

  // Write-port mux: clear writes during the sweep, else the queue head; idle fields held at zero.
  always_comb begin
    upd_valid  = 1'b0;
    upd_clear  = 1'b0;
    upd_index  = '0;
    upd_tag    = '0;
    upd_taken  = 1'b0;
    upd_btb_we = 1'b0;
    upd_target = '0;
    if (!rst) begin
      if (state == ST_INIT) begin
        upd_valid = 1'b1;
        upd_clear = 1'b1;
        upd_index = sweep_cnt;
      end else if (pop) begin
        upd_valid  = 1'b1;
        upd_index  = head.index;
        upd_tag    = head.tag;
        upd_taken  = head.taken;
        upd_btb_we = head.btb_we;
        upd_target = head.target;
      end
    end
  end

  // Status outputs come from registered state only, plus reset which forces the busy view.
  always_comb begin
    init_busy  = rst | (state == ST_INIT);
    free_slots = (CW+1)'(FIFO_DEPTH) - {1'b0, fifo_count};
    stall_req  = init_busy | (free_slots < (CW+1)'(2));
  end

endmodule

// File: tb/tb_bp_update_ctrl.sv
// Directed bench for bp_update_ctrl: clear sweep, single/dual pushes, overflow and saturation,
// EX stall, and reset in mid-drain and mid-sweep. Expected values are written out by hand.
module tb_bp_update_ctrl;
  import bp_pkg::*;

  logic             clk = 1'b0;
  logic             rst;
  logic             ex_stall;
  logic             ex_valid_1, ex_valid_2;
  logic [31:0]      ex_pc_1, ex_pc_2;
  logic             ex_is_jmp_1, ex_is_jmp_2;
  logic             ex_act_taken_1, ex_act_taken_2;
  logic [31:0]      ex_act_target_1, ex_act_target_2;
  logic             ex_pred_taken_1, ex_pred_taken_2;
  logic [31:0]      ex_pred_target_1, ex_pred_target_2;
  logic             mispred_1, mispred_2;
  logic             upd_valid, upd_clear;
  logic [IW-1:0]    upd_index;
  logic [TAG_W-1:0] upd_tag;
  logic             upd_taken, upd_btb_we;
  logic [31:0]      upd_target;
  logic             init_busy, stall_req;
  logic [7:0]       drop_cnt;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  bp_update_ctrl #(.LINES(256), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .ex_stall(ex_stall),
    .ex_valid_1(ex_valid_1), .ex_valid_2(ex_valid_2),
    .ex_pc_1(ex_pc_1), .ex_pc_2(ex_pc_2),
    .ex_is_jmp_1(ex_is_jmp_1), .ex_is_jmp_2(ex_is_jmp_2),
    .ex_act_taken_1(ex_act_taken_1), .ex_act_taken_2(ex_act_taken_2),
    .ex_act_target_1(ex_act_target_1), .ex_act_target_2(ex_act_target_2),
    .ex_pred_taken_1(ex_pred_taken_1), .ex_pred_taken_2(ex_pred_taken_2),
    .ex_pred_target_1(ex_pred_target_1), .ex_pred_target_2(ex_pred_target_2),
    .mispred_1(mispred_1), .mispred_2(mispred_2),
    .upd_valid(upd_valid), .upd_clear(upd_clear), .upd_index(upd_index),
    .upd_tag(upd_tag), .upd_taken(upd_taken), .upd_btb_we(upd_btb_we),
    .upd_target(upd_target), .init_busy(init_busy), .stall_req(stall_req),
    .drop_cnt(drop_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_ex();
    ex_valid_1 = 0; ex_pc_1 = '0; ex_is_jmp_1 = 0; ex_act_taken_1 = 0;
    ex_act_target_1 = '0; ex_pred_taken_1 = 0; ex_pred_target_1 = '0;
    ex_valid_2 = 0; ex_pc_2 = '0; ex_is_jmp_2 = 0; ex_act_taken_2 = 0;
    ex_act_target_2 = '0; ex_pred_taken_2 = 0; ex_pred_target_2 = '0;
  endtask

  task automatic slot1(input logic jmp, input logic [31:0] pc, input logic at,
                       input logic [31:0] atg, input logic pt, input logic [31:0] ptg);
    ex_valid_1 = 1; ex_is_jmp_1 = jmp; ex_pc_1 = pc; ex_act_taken_1 = at;
    ex_act_target_1 = atg; ex_pred_taken_1 = pt; ex_pred_target_1 = ptg;
  endtask

  task automatic slot2(input logic jmp, input logic [31:0] pc, input logic at,
                       input logic [31:0] atg, input logic pt, input logic [31:0] ptg);
    ex_valid_2 = 1; ex_is_jmp_2 = jmp; ex_pc_2 = pc; ex_act_taken_2 = at;
    ex_act_target_2 = atg; ex_pred_taken_2 = pt; ex_pred_target_2 = ptg;
  endtask

  // Hard stop if the sequence ever runs away.
  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1; ex_stall = 0; idle_ex();
    tick(); tick();
    // In reset: nothing written, busy and stalling, counter cleared.
    chk("rst_upd_valid", upd_valid, 0);
    chk("rst_upd_clear", upd_clear, 0);
    chk("rst_init_busy", init_busy, 1);
    chk("rst_stall_req", stall_req, 1);
    chk("rst_drop_cnt", drop_cnt, 0);

    // Sweep 0..255; taken jumps offered for the first 200 cycles must be ignored.
    slot1(1, 32'h40, 1, 32'h80, 0, 0);
    slot2(1, 32'h44, 1, 32'h88, 0, 0);
    rst = 0;
    for (int i = 0; i < 256; i++) begin
      if (i == 200) idle_ex();
      #1;
      chk($sformatf("sweep_%0d", i), {upd_valid, upd_clear, init_busy, stall_req, upd_btb_we, upd_taken, upd_index},
          {1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'(i)});
      tick();
    end
    chk("run_init_busy", init_busy, 0);
    chk("run_upd_valid", upd_valid, 0);
    chk("run_stall_req", stall_req, 0);
    chk("run_drop_cnt", drop_cnt, 0);

    // Slot 1 only: pc 0x1234 -> index 0x8D, tag 0x4; taken but predicted not-taken.
    slot1(1, 32'h0000_1234, 1, 32'h2000, 0, 32'h0);
    #1;
    chk("s1_mispred_1", mispred_1, 1);
    chk("s1_mispred_2", mispred_2, 0);
    chk("s1_not_yet", upd_valid, 0);
    tick(); idle_ex(); #1;
    chk("s1_upd", {upd_valid, upd_clear, upd_taken, upd_btb_we, upd_index, upd_tag, upd_target},
        {1'b1, 1'b0, 1'b1, 1'b1, 8'h8D, 22'h4, 32'h2000});
    tick();
    chk("s1_drained", upd_valid, 0);

    // Mispredict truth table points.
    slot1(0, 32'h10, 0, 0, 1, 32'h50);          // non-jump predicted taken
    slot2(0, 32'h14, 0, 0, 0, 32'h0);           // non-jump predicted not-taken
    #1;
    chk("mp_nonjmp_pt", mispred_1, 1);
    chk("mp_nonjmp_pnt", mispred_2, 0);
    slot1(1, 32'h10, 1, 32'h300, 1, 32'h304);   // both taken, wrong target
    slot2(1, 32'h14, 1, 32'h300, 1, 32'h300);   // both taken, right target
    ex_stall = 1;                               // keep these out of the queue
    #1;
    chk("mp_bad_target", mispred_1, 1);
    chk("mp_good_target", mispred_2, 0);
    slot1(1, 32'h10, 0, 32'h300, 0, 32'h304);   // not taken, target ignored
    ex_valid_2 = 0; ex_pred_taken_2 = 1;        // invalid slot never flags
    #1;
    chk("mp_nt_target_ignored", mispred_1, 0);
    chk("mp_invalid", mispred_2, 0);
    ex_stall = 0; idle_ex();

    // Dual push: 0x100 not taken, 0x200 taken -> index 0x40 then 0x80.
    slot1(1, 32'h100, 0, 32'h104, 0, 32'h0);
    slot2(1, 32'h200, 1, 32'h3000, 1, 32'h3000);
    tick(); idle_ex(); #1;
    chk("dual_first", {upd_valid, upd_index, upd_btb_we, upd_taken}, {1'b1, 8'h40, 1'b0, 1'b0});
    tick();
    chk("dual_second", {upd_valid, upd_index, upd_btb_we, upd_taken, upd_target},
        {1'b1, 8'h80, 1'b1, 1'b1, 32'h3000});
    tick();
    chk("dual_drained", upd_valid, 0);

    // Four back-to-back dual pushes of indices 1..8 into a depth-4 queue.
    // Occupancy after each edge: 2, 3, 4, 4; only index 8 finds no room.
    slot1(1, 32'd4, 1, 32'h1000, 1, 32'h1000); slot2(1, 32'd8, 1, 32'h1000, 1, 32'h1000);
    #1; chk("ovf_stall_0", stall_req, 0);
    tick();
    chk("ovf_a", {upd_valid, upd_index, stall_req}, {1'b1, 8'd1, 1'b0});
    slot1(1, 32'd12, 1, 32'h1000, 1, 32'h1000); slot2(1, 32'd16, 1, 32'h1000, 1, 32'h1000);
    tick();
    chk("ovf_b", {upd_valid, upd_index, stall_req, drop_cnt}, {1'b1, 8'd2, 1'b1, 8'd0});
    slot1(1, 32'd20, 1, 32'h1000, 1, 32'h1000); slot2(1, 32'd24, 1, 32'h1000, 1, 32'h1000);
    tick();
    chk("ovf_c", {upd_valid, upd_index, stall_req, drop_cnt}, {1'b1, 8'd3, 1'b1, 8'd0});
    slot1(1, 32'd28, 1, 32'h1000, 1, 32'h1000); slot2(1, 32'd32, 1, 32'h1000, 1, 32'h1000);
    tick(); idle_ex();
    chk("ovf_d", {upd_valid, upd_index, stall_req, drop_cnt}, {1'b1, 8'd4, 1'b1, 8'd1});
    tick(); chk("ovf_5", {upd_valid, upd_index}, {1'b1, 8'd5});
    tick(); chk("ovf_6", {upd_valid, upd_index, stall_req}, {1'b1, 8'd6, 1'b0});
    tick(); chk("ovf_7", {upd_valid, upd_index}, {1'b1, 8'd7});
    tick(); chk("ovf_empty", {upd_valid, stall_req, drop_cnt}, {1'b0, 1'b0, 8'd1});

    // EX stall with valid taken jumps: nothing queued, no drops, flags still live.
    ex_stall = 1;
    slot1(1, 32'h400, 1, 32'h500, 0, 32'h0);
    slot2(1, 32'h404, 1, 32'h600, 0, 32'h0);
    #1;
    chk("stall_mispred", {mispred_1, mispred_2}, 2'b11);
    tick();
    chk("stall_no_upd", {upd_valid, drop_cnt}, {1'b0, 8'd1});
    tick();
    chk("stall_no_upd2", {upd_valid, drop_cnt}, {1'b0, 8'd1});
    ex_stall = 0;

    // 300 cycles of dual pushes: 2+2+2 accepted first, then one drop per cycle -> saturates at 255.
    for (int i = 0; i < 300; i++) tick();
    idle_ex();
    chk("drop_saturate", drop_cnt, 8'd255);
    for (int i = 0; i < 4; i++) tick();
    chk("sat_drained", upd_valid, 0);

    // Reset in mid-drain: queue flushed, sweep restarts at 0, drop counter cleared.
    slot1(1, 32'h10, 1, 32'h20, 1, 32'h20);
    slot2(1, 32'h14, 1, 32'h20, 1, 32'h20);
    tick(); idle_ex();
    chk("drain_pre_rst", {upd_valid, upd_index}, {1'b1, 8'd4});
    rst = 1; #1;
    chk("drain_in_rst", {upd_valid, init_busy, stall_req}, 3'b011);
    tick(); rst = 0; #1;
    chk("drain_restart", {upd_valid, upd_clear, upd_index, drop_cnt}, {1'b1, 1'b1, 8'd0, 8'd0});
    for (int i = 0; i < 100; i++) tick();
    chk("sweep_at_100", {upd_clear, upd_index}, {1'b1, 8'd100});

    // Reset at sweep index 100: sweep starts over from 0 and runs a full 256 cycles.
    rst = 1; tick(); rst = 0; #1;
    chk("sweep_restart", {upd_valid, upd_clear, init_busy, upd_index}, {1'b1, 1'b1, 1'b1, 8'd0});
    for (int i = 0; i < 255; i++) tick();
    chk("sweep_last", {upd_clear, init_busy, upd_index}, {1'b1, 1'b1, 8'd255});
    tick();
    chk("post_flush", {upd_valid, upd_clear, init_busy, stall_req}, 4'b0000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
